// File: rtl/pb_job_arbiter_if.sv
// pb_job_arbiter_if
//   Bundles the per-channel job request signals and the packet-builder
//   handshake into one interface.
//   slave  : arbiter side (takes requests, drives the builder)
//   master : environment side (requestors, software clear, builder model)
//   Per-channel buses are flattened, channel i at [i*W +: W].
interface pb_job_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*4-1:0]      ch_byte_cnt;
    logic [NUM_CH*4-1:0]      ch_pkt_type;
    logic [NUM_CH-1:0]        ch_ecc_en;
    logic [NUM_CH-1:0]        ch_crc_en;
    logic [NUM_CH-1:0]        ch_ack;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH-1:0]        ch_err;
    logic [NUM_CH-1:0]        irq_clr;
    logic [NUM_CH-1:0]        irq_status;
    logic                     irq_out;
    logic [CH_W-1:0]          active_ch;
    logic                     pb_start;
    logic [ADDR_W-1:0]        pb_addr_in;
    logic [3:0]               pb_byte_cnt;
    logic [3:0]               pb_pkt_type;
    logic                     pb_ecc_en;
    logic                     pb_crc_en;
    logic                     pb_busy;
    logic                     pb_irq;

    modport slave (
        input  ch_req, ch_addr, ch_byte_cnt, ch_pkt_type, ch_ecc_en, ch_crc_en,
        input  irq_clr, pb_busy, pb_irq,
        output ch_ack, ch_done, ch_err, irq_status, irq_out, active_ch,
        output pb_start, pb_addr_in, pb_byte_cnt, pb_pkt_type, pb_ecc_en, pb_crc_en
    );

    modport master (
        output ch_req, ch_addr, ch_byte_cnt, ch_pkt_type, ch_ecc_en, ch_crc_en,
        output irq_clr, pb_busy, pb_irq,
        input  ch_ack, ch_done, ch_err, irq_status, irq_out, active_ch,
        input  pb_start, pb_addr_in, pb_byte_cnt, pb_pkt_type, pb_ecc_en, pb_crc_en
    );
endinterface

// File: rtl/pb_job_arbiter.sv
// pb_job_arbiter
//   Round-robin front end for the packet builder register port. NUM_CH
//   requestors post build jobs; one job at a time is granted, handed to the
//   builder with a start pulse, and supervised by a watchdog per phase
//   (waiting for busy, waiting for completion). Each channel keeps a sticky
//   done-or-error flag that software clears.
// Ports
//   clk    : clock
//   reset  : asynchronous active-high reset, aborts any job silently
//   bus    : pb_job_arbiter_if.slave
//            ch_req/ch_addr/ch_byte_cnt/ch_pkt_type/ch_ecc_en/ch_crc_en in
//            ch_ack/ch_done/ch_err one-cycle pulses out
//            irq_clr in, irq_status/irq_out out, active_ch out
//            pb_start/pb_addr_in/pb_byte_cnt/pb_pkt_type/pb_ecc_en/pb_crc_en out
//            pb_busy/pb_irq in
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | no job; pick round-robin winner and latch its config
// GRANT       | ch_ack pulse to the winner
// START       | pb_start pulse, watchdog cleared
// WAIT_BUSY   | wait for builder busy (or an early completion)
// RUN         | builder busy, wait for pb_irq
// DONE        | ch_done pulse, set sticky status
// ERR         | watchdog expired: ch_err pulse, set sticky status
module pb_job_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 1000
) (
    input  logic            clk,
    input  logic            reset,
    pb_job_arbiter_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  timer_q, timer_d;
    logic [TMO_W-1:0]  timer_inc;
    logic [CH_W-1:0]   last_q, last_d;
    logic [CH_W-1:0]   active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [3:0]        pkt_type_q, pkt_type_d;
    logic              ecc_q, ecc_d;
    logic              crc_q, crc_d;
    logic [NUM_CH-1:0] status_q, status_d;
    logic              irq_out_q;

    logic              win_vld;
    logic [CH_W-1:0]   win_idx;
    logic [NUM_CH-1:0] ack_vec, done_vec, err_vec;
    logic              start;

    assign timer_inc = timer_q + TMO_W'(1);

    // Search starts one past the last grant so every requester is served
    // before anyone gets a second turn.
    always_comb begin
        int idx;
        logic [CH_W-1:0] idx_c;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        idx_c   = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx   = (int'(last_q) + off) % NUM_CH;
            idx_c = CH_W'(idx);
            if (!win_vld && bus.ch_req[idx_c]) begin
                win_vld = 1'b1;
                win_idx = idx_c;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_d     = last_q;
        active_d   = active_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        pkt_type_d = pkt_type_q;
        ecc_d      = ecc_q;
        crc_d      = crc_q;
        // Clear first so a DONE/ERR set in the same cycle wins.
        status_d   = status_q & ~bus.irq_clr;
        ack_vec    = '0;
        done_vec   = '0;
        err_vec    = '0;
        start      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    active_d   = win_idx;
                    last_d     = win_idx;
                    addr_d     = bus.ch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    byte_cnt_d = bus.ch_byte_cnt[int'(win_idx)*4 +: 4];
                    pkt_type_d = bus.ch_pkt_type[int'(win_idx)*4 +: 4];
                    ecc_d      = bus.ch_ecc_en[win_idx];
                    crc_d      = bus.ch_crc_en[win_idx];
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                ack_vec[active_q] = 1'b1;
                state_d           = S_START;
            end
            S_START: begin
                start   = 1'b1;
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.pb_irq) begin
                    state_d = S_DONE;
                end else if (bus.pb_busy) begin
                    timer_d = '0;
                    state_d = S_RUN;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMO_LAST) state_d = S_ERR;
                end
            end
            S_RUN: begin
                if (bus.pb_irq) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMO_LAST) state_d = S_ERR;
                end
            end
            S_DONE: begin
                done_vec[active_q] = 1'b1;
                status_d[active_q] = 1'b1;
                state_d            = S_IDLE;
            end
            S_ERR: begin
                err_vec[active_q]  = 1'b1;
                status_d[active_q] = 1'b1;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            last_q     <= LAST_CH;
            active_q   <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            pkt_type_q <= '0;
            ecc_q      <= 1'b0;
            crc_q      <= 1'b0;
            status_q   <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            last_q     <= last_d;
            active_q   <= active_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            pkt_type_q <= pkt_type_d;
            ecc_q      <= ecc_d;
            crc_q      <= crc_d;
            status_q   <= status_d;
            irq_out_q  <= |status_q;
        end
    end

    assign bus.ch_ack      = ack_vec;
    assign bus.ch_done     = done_vec;
    assign bus.ch_err      = err_vec;
    assign bus.irq_status  = status_q;
    assign bus.irq_out     = irq_out_q;
    assign bus.active_ch   = active_q;
    assign bus.pb_start    = start;
    assign bus.pb_addr_in  = addr_q;
    assign bus.pb_byte_cnt = byte_cnt_q;
    assign bus.pb_pkt_type = pkt_type_q;
    assign bus.pb_ecc_en   = ecc_q;
    assign bus.pb_crc_en   = crc_q;
endmodule

// File: tb/tb_pb_job_arbiter.sv
// tb_pb_job_arbiter
//   Scoreboard bench: each job's expected ack/start/done/err events are
//   queued when the job is set up and popped by a monitor as the arbiter
//   emits them. Timing and status checks are made inline by the sequence.
module tb_pb_job_arbiter;
    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 32;
    localparam int TMO_W   = 16;
    localparam int TMO_CYC = 16;

    typedef enum int {EV_ACK, EV_START, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          ch;
        logic [31:0] addr;
        logic [3:0]  bc;
        logic [3:0]  pt;
        logic        ecc;
        logic        crc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pb_job_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

    pb_job_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .TMO_W  (TMO_W),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cfg_addr [NUM_CH];
    logic [3:0]  cfg_bc   [NUM_CH];
    logic [3:0]  cfg_pt   [NUM_CH];
    logic        cfg_ecc  [NUM_CH];
    logic        cfg_crc  [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input logic [31:0] a, input logic [3:0] bc,
                           input logic [3:0] pt, input logic ecc, input logic crc);
        cfg_addr[ch] = a;
        cfg_bc[ch]   = bc;
        cfg_pt[ch]   = pt;
        cfg_ecc[ch]  = ecc;
        cfg_crc[ch]  = crc;
        bus.ch_addr[ch*ADDR_W +: ADDR_W] = a;
        bus.ch_byte_cnt[ch*4 +: 4]       = bc;
        bus.ch_pkt_type[ch*4 +: 4]       = pt;
        bus.ch_ecc_en[ch]                = ecc;
        bus.ch_crc_en[ch]                = crc;
    endtask

    task automatic push_ev(input ev_kind_t k, input int ch);
        exp_t e;
        e.kind = k;
        e.ch   = ch;
        e.addr = cfg_addr[ch];
        e.bc   = cfg_bc[ch];
        e.pt   = cfg_pt[ch];
        e.ecc  = cfg_ecc[ch];
        e.crc  = cfg_crc[ch];
        sb_q.push_back(e);
    endtask

    task automatic push_job(input int ch, input ev_kind_t fin);
        push_ev(EV_ACK, ch);
        push_ev(EV_START, ch);
        push_ev(fin, ch);
    endtask

    task automatic sb_match(input ev_kind_t k);
        exp_t e;
        chk("sb_has_entry", 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_kind", 64'(k), 64'(e.kind));
            case (k)
                EV_ACK: begin
                    chk("ack_vec", 64'(bus.ch_ack), 64'(1) << e.ch);
                    chk("ack_active_ch", 64'(bus.active_ch), 64'(e.ch));
                end
                EV_START: begin
                    chk("start_active_ch", 64'(bus.active_ch), 64'(e.ch));
                    chk("start_addr", 64'(bus.pb_addr_in), 64'(e.addr));
                    chk("start_byte_cnt", 64'(bus.pb_byte_cnt), 64'(e.bc));
                    chk("start_pkt_type", 64'(bus.pb_pkt_type), 64'(e.pt));
                    chk("start_ecc", 64'(bus.pb_ecc_en), 64'(e.ecc));
                    chk("start_crc", 64'(bus.pb_crc_en), 64'(e.crc));
                end
                EV_DONE: chk("done_vec", 64'(bus.ch_done), 64'(1) << e.ch);
                default: chk("err_vec", 64'(bus.ch_err), 64'(1) << e.ch);
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ch_ack != '0)  sb_match(EV_ACK);
            if (bus.pb_start)      sb_match(EV_START);
            if (bus.ch_done != '0) sb_match(EV_DONE);
            if (bus.ch_err != '0)  sb_match(EV_ERR);
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        while (!bus.pb_start && n < 100) begin
            tick();
            n++;
        end
        chk("wait_pb_start", 64'(bus.pb_start), 64'(1));
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (bus.ch_ack == '0 && n < 100) begin
            tick();
            n++;
        end
        chk("wait_ack", 64'(bus.ch_ack != '0), 64'(1));
    endtask

    task automatic wait_err(output int n);
        n = 0;
        while (bus.ch_err == '0 && n < 4*TMO_CYC) begin
            tick();
            n++;
        end
        chk("wait_err", 64'(bus.ch_err != '0), 64'(1));
    endtask

    // Called in the pb_start cycle; returns in the DONE cycle.
    task automatic run_normal(input int busy_cyc);
        bus.pb_busy = 1'b1;
        repeat (busy_cyc) tick();
        bus.pb_busy = 1'b0;
        bus.pb_irq  = 1'b1;
        tick();
        bus.pb_irq  = 1'b0;
    endtask

    // Completion without busy ever being seen.
    task automatic run_short();
        tick();
        bus.pb_irq = 1'b1;
        tick();
        bus.pb_irq = 1'b0;
    endtask

    task automatic clr_all();
        bus.irq_clr = '1;
        tick();
        bus.irq_clr = '0;
        chk("clr_status", 64'(bus.irq_status), 64'(0));
        tick();
        chk("clr_irq_out", 64'(bus.irq_out), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        reset           = 1'b1;
        bus.ch_req      = '0;
        bus.ch_addr     = '0;
        bus.ch_byte_cnt = '0;
        bus.ch_pkt_type = '0;
        bus.ch_ecc_en   = '0;
        bus.ch_crc_en   = '0;
        bus.irq_clr     = '0;
        bus.pb_busy     = 1'b0;
        bus.pb_irq      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) set_cfg(i, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        tick();

        chk("rst_ack", 64'(bus.ch_ack), 64'(0));
        chk("rst_done", 64'(bus.ch_done), 64'(0));
        chk("rst_err", 64'(bus.ch_err), 64'(0));
        chk("rst_status", 64'(bus.irq_status), 64'(0));
        chk("rst_irq_out", 64'(bus.irq_out), 64'(0));
        chk("rst_start", 64'(bus.pb_start), 64'(0));
        chk("rst_addr", 64'(bus.pb_addr_in), 64'(0));
        chk("rst_active", 64'(bus.active_ch), 64'(0));
        reset = 1'b0;
        tick();

        // Single job on channel 2, config changed after ack must not leak.
        set_cfg(2, 32'h0000_1000, 4'd7, 4'd3, 1'b1, 1'b0);
        push_job(2, EV_DONE);
        bus.ch_req[2] = 1'b1;
        tick();
        chk("t1_ack_latency", 64'(bus.ch_ack), 64'(4'b0100));
        bus.ch_req[2] = 1'b0;
        bus.ch_addr[2*ADDR_W +: ADDR_W] = 32'hDEAD_BEEF;
        bus.ch_byte_cnt[2*4 +: 4]       = 4'hF;
        tick();
        chk("t1_start_latency", 64'(bus.pb_start), 64'(1));
        run_normal(10);
        chk("t1_done", 64'(bus.ch_done), 64'(4'b0100));
        tick();
        chk("t1_status", 64'(bus.irq_status), 64'(4'b0100));
        chk("t1_irq_out_lag", 64'(bus.irq_out), 64'(0));
        chk("t1_addr_hold", 64'(bus.pb_addr_in), 64'(32'h0000_1000));
        tick();
        chk("t1_irq_out", 64'(bus.irq_out), 64'(1));
        clr_all();

        // Fairness from reset: all channels requesting.
        do_reset();
        for (int i = 0; i < NUM_CH; i++)
            set_cfg(i, 32'h100 * (i + 1) + 32'h10, 4'(i + 1), 4'(i + 8), i[0], i[1]);
        for (int j = 0; j < 5; j++) push_job(order[j], EV_DONE);
        bus.ch_req = '1;
        for (int j = 0; j < 5; j++) begin
            wait_start(n);
            chk("fair_order", 64'(bus.active_ch), 64'(order[j]));
            if (j == 4) bus.ch_req = '0;
            run_normal(5);
        end
        tick();
        chk("fair_status", 64'(bus.irq_status), 64'(4'b1111));
        clr_all();

        // Busy never rises.
        set_cfg(1, 32'hA5A5_0001, 4'd2, 4'd5, 1'b0, 1'b1);
        push_job(1, EV_ERR);
        bus.ch_req[1] = 1'b1;
        tick();
        bus.ch_req[1] = 1'b0;
        wait_start(n);
        wait_err(n);
        chk("busy_tmo_cycles", 64'(n), 64'(TMO_CYC));
        tick();
        chk("busy_tmo_status", 64'(bus.irq_status), 64'(4'b0010));
        clr_all();

        // Busy rises, completion never comes; ch0 queued behind it.
        set_cfg(3, 32'h3333_0000, 4'd9, 4'd1, 1'b1, 1'b1);
        push_job(3, EV_ERR);
        bus.ch_req[3] = 1'b1;
        tick();
        bus.ch_req[3] = 1'b0;
        set_cfg(0, 32'h0BAD_F00D, 4'd4, 4'd6, 1'b1, 1'b0);
        bus.ch_req[0] = 1'b1;
        wait_start(n);
        bus.pb_busy = 1'b1;
        wait_err(n);
        chk("run_tmo_cycles", 64'(n), 64'(TMO_CYC + 1));
        bus.pb_busy = 1'b0;
        push_job(0, EV_DONE);
        wait_ack(n);
        chk("regrant_latency", 64'(n), 64'(2));
        bus.ch_req[0] = 1'b0;
        wait_start(n);
        run_short();
        chk("short_done", 64'(bus.ch_done), 64'(4'b0001));
        tick();
        chk("run_tmo_status", 64'(bus.irq_status), 64'(4'b1001));
        clr_all();

        // Clear racing DONE on channel 1.
        set_cfg(1, 32'h1111_2222, 4'd1, 4'd2, 1'b0, 1'b0);
        push_job(1, EV_DONE);
        bus.ch_req[1] = 1'b1;
        tick();
        bus.ch_req[1] = 1'b0;
        wait_start(n);
        run_normal(3);
        bus.irq_clr[1] = 1'b1;
        tick();
        bus.irq_clr[1] = 1'b0;
        chk("race_set_wins", 64'(bus.irq_status), 64'(4'b0010));
        tick();
        chk("race_irq_out", 64'(bus.irq_out), 64'(1));
        bus.irq_clr[1] = 1'b1;
        tick();
        bus.irq_clr[1] = 1'b0;
        chk("lone_clr_status", 64'(bus.irq_status), 64'(0));
        chk("lone_clr_irq_out_lag", 64'(bus.irq_out), 64'(1));
        tick();
        chk("lone_clr_irq_out", 64'(bus.irq_out), 64'(0));

        // Reset in the middle of RUN.
        set_cfg(3, 32'h7777_0003, 4'd3, 4'd3, 1'b1, 1'b0);
        push_ev(EV_ACK, 3);
        push_ev(EV_START, 3);
        bus.ch_req[3] = 1'b1;
        tick();
        bus.ch_req[3] = 1'b0;
        wait_start(n);
        bus.pb_busy = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_addr", 64'(bus.pb_addr_in), 64'(0));
        chk("mid_rst_byte_cnt", 64'(bus.pb_byte_cnt), 64'(0));
        chk("mid_rst_active", 64'(bus.active_ch), 64'(0));
        chk("mid_rst_done", 64'(bus.ch_done), 64'(0));
        chk("mid_rst_err", 64'(bus.ch_err), 64'(0));
        chk("mid_rst_ecc", 64'(bus.pb_ecc_en), 64'(0));
        bus.pb_busy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("mid_rst_sb_empty", 64'(sb_q.size()), 64'(0));
        chk("mid_rst_status", 64'(bus.irq_status), 64'(0));
        push_job(3, EV_DONE);
        bus.ch_req[3] = 1'b1;
        tick();
        chk("post_rst_ack", 64'(bus.ch_ack), 64'(4'b1000));
        bus.ch_req[3] = 1'b0;
        wait_start(n);
        run_short();
        repeat (3) tick();
        chk("final_sb_empty", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pb_job_arbiter.md
Name: pb_job_arbiter

Overview:
- Multi-channel front end for the packet builder's register port.
- NUM_CH independent requestors each present a build job (address, byte count, packet type, ECC/CRC enables).
- The block grants jobs round-robin and drives the single pb_start/pb_busy/pb_irq handshake to the builder. It also enforces a watchdog timeout and keeps a per-channel sticky completion/error status that software clears.
- Sits between the register bank and the packet builder, replacing the direct one-master pb register connection.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16)
- ADDR_W, 32, width of the job address
- TMO_W, 16, width of the watchdog counter
- TMO_CYC, 1000, cycles allowed per phase (busy-rise, completion) before a job is declared timed out; must be < 2**TMO_W

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ch_req  in  NUM_CH  per-channel job request level
- ch_addr  in  NUM_CH*ADDR_W  per-channel job address, channel i at [i*ADDR_W +: ADDR_W]
- ch_byte_cnt  in  NUM_CH*4  per-channel byte count
- ch_pkt_type  in  NUM_CH*4  per-channel packet type
- ch_ecc_en  in  NUM_CH  per-channel ECC enable
- ch_crc_en  in  NUM_CH  per-channel CRC enable
- ch_ack  out  NUM_CH  one-cycle job-accepted pulse
- ch_done  out  NUM_CH  one-cycle job-complete pulse
- ch_err  out  NUM_CH  one-cycle timeout pulse
- irq_clr  in  NUM_CH  per-channel status clear (pulse)
- irq_status  out  NUM_CH  sticky per-channel done-or-error flag
- irq_out  out  1  OR of irq_status
- active_ch  out  $clog2(NUM_CH)  owner of the current job, valid when not IDLE
- pb_start  out  1  builder start pulse
- pb_addr_in  out  ADDR_W  job address to builder
- pb_byte_cnt  out  4  byte count to builder
- pb_pkt_type  out  4  packet type to builder
- pb_ecc_en  out  1  ECC enable to builder
- pb_crc_en  out  1  CRC enable to builder
- pb_busy  in  1  builder busy
- pb_irq  in  1  builder completion pulse

Behaviour:
- Reset state:
  - All outputs are 0, FSM is IDLE, timer is 0, irq_status is 0.
  - The round-robin pointer is set so that channel 0 has top priority first.
  - Reset mid-job aborts immediately; no done or err pulse is issued.
- FSM states: IDLE, GRANT, START, WAIT_BUSY, RUN, DONE, ERR.
- IDLE:
  - If any ch_req is high, select a winner: the first requesting channel at or after (last_grant+1) mod NUM_CH.
  - Latch the winner's config into the pb_* registers, set active_ch, go to GRANT.
- GRANT: ch_ack[winner]=1 for exactly one cycle, then go to START.
  - Requestors hold ch_req and config stable until ack; dropping ch_req earlier is illegal.
- START: pb_start=1 for exactly one cycle, timer cleared, go to WAIT_BUSY.
- WAIT_BUSY:
  - pb_irq=1 → DONE (a short job without an observed busy is legal).
  - Otherwise pb_busy=1 → RUN, timer cleared.
  - Otherwise timer++; timer==TMO_CYC-1 → ERR.
- RUN:
  - pb_irq=1 → DONE.
  - Otherwise timer++; timer==TMO_CYC-1 → ERR.
- DONE: ch_done[active_ch]=1 for one cycle, set irq_status[active_ch], go to IDLE.
- ERR: ch_err[active_ch]=1 for one cycle, set irq_status[active_ch], go to IDLE.
- Latency: ch_req seen at edge t → ch_ack in cycle t+1 → pb_start in cycle t+2. The next grant is evaluated in the cycle after DONE/ERR.
- pb_addr_in, pb_byte_cnt, pb_pkt_type, pb_ecc_en, pb_crc_en hold their values from GRANT until the next grant; changes on ch_* inputs after ack are ignored.
- irq_status:
  - Set by DONE/ERR, cleared by irq_clr[i].
  - Simultaneous set and clear on the same channel: set wins.
  - irq_out is registered and equals |irq_status, one cycle after the status change.
- pb_irq or pb_busy outside WAIT_BUSY/RUN is ignored.
- Arbitration is only re-evaluated in IDLE. A single requester re-granted back-to-back is legal.

Test Plan:
- Single job: ch_req[2]=1 with addr 0x1000, byte_cnt 7, type 3, ecc_en 1 → ack[2] in cycle 1, pb_start in cycle 2 with pb_addr_in=0x1000, pb_byte_cnt=7, pb_pkt_type=3. Busy for 10 cycles then pb_irq → ch_done[2] pulse, irq_status=4'b0100, irq_out=1.
- Fairness: all 4 channels request continuously, each job completes after 5 busy cycles → grant order 0,1,2,3,0; no channel granted twice before the others.
- Busy timeout: with TMO_CYC=8, pb_busy never rises → ch_err[active] exactly 8 cycles after pb_start; FSM back in IDLE; irq_status bit set.
- Run timeout: pb_busy rises, pb_irq never comes → ch_err after TMO_CYC cycles in RUN. The next requester is then granted normally.
- Clear race: irq_clr[1] in the same cycle as DONE for channel 1 → irq_status[1] stays 1. A later lone irq_clr[1] → 0, and irq_out falls one cycle later.
- Reset mid-RUN: assert reset with the job active → all outputs 0 immediately, no done/err pulse. After release, ch_req[3] alone is granted with ch_ack[3].
